rom_read_arbiter: RTL and testbench

Shares the two synchronous read ports of the dual-port ROM (1-cycle registered read) between NREQ independent requesters. Each cycle it grants up to two requests in round-robin order, one to port A and one to port B. It tracks each granted read through the ROM latency and returns the data to the issuing requester with a one-cycle valid pulse. It sits between the ROM instance and the lookup clients, such as microcode, font and table readers.

---
 rtl/rom_read_arbiter.sv | 120 ++++++++++++
 tb/tb_rom_read_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// rtl/rom_read_arbiter.sv - round-robin arbiter sharing both ports of a dual-port ROM among requesters
module rom_read_arbiter #(
  parameter int width   = 1,
  parameter int widthad = 1,
  parameter int NREQ    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*widthad-1:0] req_addr,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [NREQ*width-1:0]   rsp_data,
  output logic [widthad-1:0]      rom_addr_a,
  output logic [widthad-1:0]      rom_addr_b,
  input  logic [width-1:0]        rom_q_a,
  input  logic [width-1:0]        rom_q_b
);

  localparam int            PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);
  localparam logic [PW-1:0] ONE  = PW'(1);

  logic [PW-1:0]         ptr_q, ptr_d;
  logic                  s1_grant_a_q, s1_grant_a_d;
  logic                  s1_grant_b_q, s1_grant_b_d;
  logic [PW-1:0]         s1_id_a_q, s1_id_a_d;
  logic [PW-1:0]         s1_id_b_q, s1_id_b_d;
  logic [NREQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic [NREQ*width-1:0] rsp_data_q, rsp_data_d;

  logic          grant_a, grant_b;
  logic [PW-1:0] id_a, id_b;
  logic [PW-1:0] scan_idx;

  // Requester index successor, wrapping at NREQ-1 (NREQ need not be a power of two)
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == LAST) ? '0 : v + ONE;
  endfunction

  // Round-robin scan from ptr: first pending requester wins port A, second wins port B
  always_comb begin
    grant_a  = 1'b0;
    grant_b  = 1'b0;
    id_a     = '0;
    id_b     = '0;
    scan_idx = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!rst && req_valid[scan_idx]) begin
        if (!grant_a) begin
          grant_a = 1'b1;
          id_a    = scan_idx;
        end else if (!grant_b) begin
          grant_b = 1'b1;
          id_b    = scan_idx;
        end
      end
      scan_idx = wrap_inc(scan_idx);
    end
  end

  // Grant decode, ROM address steering, pointer advance and S1 capture
  always_comb begin
    req_ready = '0;
    if (grant_a) req_ready[id_a] = 1'b1;
    if (grant_b) req_ready[id_b] = 1'b1;

    rom_addr_a = grant_a ? req_addr[int'(id_a)*widthad +: widthad] : '0;
    rom_addr_b = grant_b ? req_addr[int'(id_b)*widthad +: widthad] : '0;

    // Pointer moves just past the last requester served this cycle
    ptr_d = ptr_q;
    if (grant_b)      ptr_d = wrap_inc(id_b);
    else if (grant_a) ptr_d = wrap_inc(id_a);

    s1_grant_a_d = grant_a;
    s1_grant_b_d = grant_b;
    s1_id_a_d    = id_a;
    s1_id_b_d    = id_b;
  end

  // Route the ROM words of last cycle's grants back to their requesters as a one-cycle pulse
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    if (s1_grant_a_q) begin
      rsp_valid_d[s1_id_a_q]                     = 1'b1;
      rsp_data_d[int'(s1_id_a_q)*width +: width] = rom_q_a;
    end
    if (s1_grant_b_q) begin
      rsp_valid_d[s1_id_b_q]                     = 1'b1;
      rsp_data_d[int'(s1_id_b_q)*width +: width] = rom_q_b;
    end
  end

  // State registers; reset drops any read still in S1
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q        <= '0;
      s1_grant_a_q <= 1'b0;
      s1_grant_b_q <= 1'b0;
      s1_id_a_q    <= '0;
      s1_id_b_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      s1_grant_a_q <= s1_grant_a_d;
      s1_grant_b_q <= s1_grant_b_d;
      s1_id_a_q    <= s1_id_a_d;
      s1_id_b_q    <= s1_id_b_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// tb/tb_rom_read_arbiter.sv - self-checking bench for rom_read_arbiter
module tb_rom_read_arbiter;

  localparam int W  = 8;
  localparam int AW = 4;
  localparam int N  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*W-1:0]  rsp_data;
  logic [AW-1:0]   rom_addr_a, rom_addr_b;
  logic [W-1:0]    rom_q_a = '0;
  logic [W-1:0]    rom_q_b = '0;

  int n_checks = 0;
  int n_fail   = 0;

  rom_read_arbiter #(.width(W), .widthad(AW), .NREQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rom_addr_a(rom_addr_a), .rom_addr_b(rom_addr_b),
    .rom_q_a(rom_q_a), .rom_q_b(rom_q_b)
  );

  always #5 clk = ~clk;

  // ROM contents: word[k] = k*3 mod 256
  function automatic logic [W-1:0] rom_word(input logic [AW-1:0] a);
    return W'((int'(a) * 3) % 256);
  endfunction

  // Dual-port ROM with one-cycle registered read
  always @(posedge clk) begin
    rom_q_a <= rom_word(rom_addr_a);
    rom_q_b <= rom_word(rom_addr_b);
  end

  // Reference model: expected responses scheduled by due cycle
  typedef struct {
    int         due;
    int         id;
    logic [W-1:0] data;
  } rsp_t;

  rsp_t         pend[$];
  int           m_ptr = 0;
  int           m_next_ptr = 0;
  logic [W-1:0] m_last [N];
  int           cyc = 0;
  bit           have_prev = 0;
  logic         cur_rst = 1'b1;

  logic [N-1:0]   exp_ready, exp_rsp_valid;
  logic [AW-1:0]  exp_aa, exp_ab;
  logic [N*W-1:0] exp_rsp_data;
  logic [N*4+AW*2+N*W-1:0] got_all, exp_all;

  initial foreach (m_last[i]) m_last[i] = '0;

  task automatic model_commit();
    if (cur_rst) begin
      m_ptr = 0;
      foreach (m_last[i]) m_last[i] = '0;
      for (int j = pend.size() - 1; j >= 0; j--)
        if (pend[j].due > cyc) pend.delete(j);
    end else begin
      m_ptr = m_next_ptr;
    end
    cyc++;
  endtask

  // Drive one cycle of inputs and compute what the outputs must be in that cycle
  task automatic apply(input logic r, input logic [N-1:0] v, input logic [N*AW-1:0] a);
    int order[$];
    @(negedge clk);
    if (have_prev) model_commit();
    have_prev = 1;
    rst = r; req_valid = v; req_addr = a; cur_rst = r;
    #1;
    exp_ready = '0; exp_aa = '0; exp_ab = '0; m_next_ptr = m_ptr;
    if (!r) begin
      for (int k = 0; k < N; k++)
        if (v[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
      for (int g = 0; g < order.size() && g < 2; g++) begin
        exp_ready[order[g]] = 1'b1;
        if (g == 0) exp_aa = a[order[g]*AW +: AW];
        else        exp_ab = a[order[g]*AW +: AW];
        pend.push_back('{cyc + 2, order[g], rom_word(a[order[g]*AW +: AW])});
        m_next_ptr = (order[g] + 1) % N;
      end
    end
    exp_rsp_valid = '0;
    for (int j = pend.size() - 1; j >= 0; j--) begin
      if (pend[j].due == cyc) begin
        exp_rsp_valid[pend[j].id] = 1'b1;
        m_last[pend[j].id] = pend[j].data;
        pend.delete(j);
      end
    end
    for (int i = 0; i < N; i++) exp_rsp_data[i*W +: W] = m_last[i];
    got_all = {req_ready, rom_addr_a, rom_addr_b, rsp_valid, rsp_data};
    exp_all = {exp_ready, exp_aa, exp_ab, exp_rsp_valid, exp_rsp_data};
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      apply(1'b1, N'($urandom), (N*AW)'($urandom));
      n_checks++;
      if (got_all !== exp_all) begin
        n_fail++; $display("FAIL reset_model cyc=%0d got %h expected %h", cyc, got_all, exp_all);
      end
      n_checks++;
      if ({req_ready, rom_addr_a, rom_addr_b} !== '0) begin
        n_fail++; $display("FAIL reset_outputs got %h %h %h expected 0", req_ready, rom_addr_a, rom_addr_b);
      end
    end
    while (cyc < 9) begin
      apply(1'b0, '0, '0);
      n_checks++;
      if (got_all !== exp_all) begin
        n_fail++; $display("FAIL reset_idle cyc=%0d got %h expected %h", cyc, got_all, exp_all);
      end
    end
  endtask

  task automatic test_single_read();
    logic [N*AW-1:0] a = '0;
    a[2*AW +: AW] = 4'd5;
    apply(1'b0, 4'b0100, a);
    n_checks++;
    if (req_ready !== 4'b0100) begin
      n_fail++; $display("FAIL single_ready got %b expected 0100", req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (got_all !== exp_all) begin
        n_fail++; $display("FAIL single_model cyc=%0d got %h expected %h", cyc, got_all, exp_all);
      end
      if (c == 2) begin
        n_checks++;
        if (rsp_valid !== 4'b0100 || rsp_data[2*W +: W] !== 8'h0F) begin
          n_fail++; $display("FAIL single_rsp got %b/%h expected 0100/0f", rsp_valid, rsp_data[2*W +: W]);
        end
      end
      if (c < 2) apply(1'b0, '0, '0);
    end
  endtask

  task automatic test_wrap();
    logic [N*AW-1:0] a = '0;
    a[3*AW +: AW] = 4'd9;
    a[0*AW +: AW] = 4'd2;
    apply(1'b0, 4'b1001, a);
    n_checks++;
    if (req_ready !== 4'b1001 || rom_addr_a !== 4'd9 || rom_addr_b !== 4'd2) begin
      n_fail++; $display("FAIL wrap_grant got %b %h %h expected 1001 9 2", req_ready, rom_addr_a, rom_addr_b);
    end
    apply(1'b0, 4'b1111, (N*AW)'($urandom));
    n_checks++;
    if (req_ready !== 4'b0110) begin
      n_fail++; $display("FAIL wrap_next_ptr got %b expected 0110", req_ready);
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (got_all !== exp_all) begin
        n_fail++; $display("FAIL wrap_model cyc=%0d got %h expected %h", cyc, got_all, exp_all);
      end
      apply(1'b0, '0, '0);
    end
  endtask

  task automatic test_dual_issue();
    logic [N*AW-1:0] a = '0;
    apply(1'b1, '0, '0);
    a[0*AW +: AW] = 4'd1;
    a[3*AW +: AW] = 4'd2;
    apply(1'b0, 4'b1001, a);
    n_checks++;
    if (req_ready !== 4'b1001) begin
      n_fail++; $display("FAIL dual_ready got %b expected 1001", req_ready);
    end
    apply(1'b0, 4'b1111, (N*AW)'($urandom));
    n_checks++;
    if (req_ready !== 4'b0011) begin
      n_fail++; $display("FAIL dual_ptr got %b expected 0011", req_ready);
    end
    apply(1'b0, '0, '0);
    n_checks++;
    if (rsp_valid !== 4'b1001 || rsp_data[0 +: W] !== 8'h03 || rsp_data[3*W +: W] !== 8'h06) begin
      n_fail++; $display("FAIL dual_rsp got %b %h %h expected 1001 03 06", rsp_valid, rsp_data[0 +: W], rsp_data[3*W +: W]);
    end
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (got_all !== exp_all) begin
        n_fail++; $display("FAIL dual_model cyc=%0d got %h expected %h", cyc, got_all, exp_all);
      end
      apply(1'b0, '0, '0);
    end
  endtask

  task automatic test_full_contention();
    int cnt [N];
    foreach (cnt[i]) cnt[i] = 0;
    apply(1'b1, '0, '0);
    for (int k = 0; k < 9; k++) begin
      apply(1'b0, (k < 6) ? 4'b1111 : 4'b0000, (N*AW)'($urandom));
      n_checks++;
      if (got_all !== exp_all) begin
        n_fail++; $display("FAIL contention_model cyc=%0d got %h expected %h", cyc, got_all, exp_all);
      end
      if (k < 6) begin
        n_checks++;
        if (req_ready !== ((k % 2 == 0) ? 4'b0011 : 4'b1100)) begin
          n_fail++; $display("FAIL contention_pair k=%0d got %b", k, req_ready);
        end
      end
      for (int i = 0; i < N; i++) if (rsp_valid[i]) cnt[i]++;
    end
    for (int i = 0; i < N; i++) begin
      n_checks++;
      if (cnt[i] != 3) begin
        n_fail++; $display("FAIL contention_count req=%0d got %0d expected 3", i, cnt[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N*AW-1:0] a;
    logic [W-1:0]    got[$];
    for (int k = 0; k < 11; k++) begin
      a = (N*AW)'($urandom);
      a[1*AW +: AW] = AW'(k);
      apply(1'b0, (k < 8) ? 4'b0010 : 4'b0000, a);
      n_checks++;
      if (got_all !== exp_all) begin
        n_fail++; $display("FAIL b2b_model cyc=%0d got %h expected %h", cyc, got_all, exp_all);
      end
      if (rsp_valid[1]) got.push_back(rsp_data[1*W +: W]);
    end
    n_checks++;
    if (got.size() != 8) begin
      n_fail++; $display("FAIL b2b_count got %0d expected 8", got.size());
    end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      n_checks++;
      if (got[k] !== W'(k * 3)) begin
        n_fail++; $display("FAIL b2b_data k=%0d got %h expected %h", k, got[k], W'(k * 3));
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [N*AW-1:0] a = '0;
    a[0 +: AW] = 4'd4;
    apply(1'b0, 4'b0001, a);
    apply(1'b1, '0, '0);
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (rsp_valid !== '0 || got_all !== exp_all) begin
        n_fail++; $display("FAIL midflight_quiet c=%0d got %b expected 0000", c, rsp_valid);
      end
      if (c < 2) apply(1'b0, '0, '0);
    end
    a = '0;
    a[3*AW +: AW] = 4'd7;
    apply(1'b0, 4'b1000, a);
    n_checks++;
    if (req_ready !== 4'b1000 || rom_addr_a !== 4'd7 || rom_addr_b !== 4'd0) begin
      n_fail++; $display("FAIL midflight_after got %b %h %h expected 1000 7 0", req_ready, rom_addr_a, rom_addr_b);
    end
    for (int c = 0; c < 3; c++) begin
      apply(1'b0, '0, '0);
      n_checks++;
      if (got_all !== exp_all) begin
        n_fail++; $display("FAIL midflight_model cyc=%0d got %h expected %h", cyc, got_all, exp_all);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      apply(($urandom_range(0, 99) < 3) ? 1'b1 : 1'b0, N'($urandom), (N*AW)'($urandom));
      n_checks++;
      if (got_all !== exp_all) begin
        n_fail++; $display("FAIL random_model cyc=%0d got %h expected %h", cyc, got_all, exp_all);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_wrap();
    test_dual_issue();
    test_full_contention();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
